// File: rtl/question_pixel_fetch_if.sv
// Pixel-stream and ROM bus between the VGA timing side, the question-image ROM
// and the colour output stage.
interface question_pixel_fetch_if;
  logic        frame_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        show;
  logic        hide;
  logic [13:0] rom_addr;
  logic [11:0] rom_data;
  logic [11:0] rgb;
  logic        busy;

  modport master (
    output frame_tick,
    output pixel_x,
    output pixel_y,
    output video_on,
    output show,
    output hide,
    input  rom_addr,
    output rom_data,
    input  rgb,
    input  busy
  );

  modport slave (
    input  frame_tick,
    input  pixel_x,
    input  pixel_y,
    input  video_on,
    input  show,
    input  hide,
    output rom_addr,
    input  rom_data,
    output rgb,
    output busy
  );
endinterface

// File: rtl/question_pixel_fetch.sv
// Question-image address generator and output stage: maps screen coordinates to
// ROM addresses, aligns flags with the ROM latency and runs a top-down reveal.
module question_pixel_fetch #(
  parameter int unsigned X0          = 256,
  parameter int unsigned Y0          = 176,
  parameter int unsigned IMG_W       = 128,
  parameter int unsigned IMG_H       = 128,
  parameter int unsigned REVEAL_STEP = 8,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input logic                  clk,
  input logic                  reset,
  question_pixel_fetch_if.slave vga
);

  typedef enum logic [1:0] {StHidden, StReveal, StShown} state_e;

  localparam logic [10:0] XLo = 11'(X0);
  localparam logic [10:0] XHi = 11'(X0 + IMG_W);
  localparam logic [10:0] YLo = 11'(Y0);
  localparam logic [10:0] YHi = 11'(Y0 + IMG_H);
  localparam logic [8:0]  RowsMax = 9'(IMG_H);
  localparam logic [8:0]  RowsStep = 9'(REVEAL_STEP);

  state_e      state_q, state_d;
  logic [7:0]  rows_q, rows_d;
  logic        busy_q, busy_d;
  logic [8:0]  rows_sum;

  logic        in_win;
  logic        vis;
  logic [9:0]  dx, dy;
  logic [13:0] addr_d;

  logic [13:0] rom_addr_q;
  logic        vis_q, von_q;
  logic        vis_d2_q, von_d2_q;
  logic [11:0] rgb_q, rgb_d;

  // Reveal FSM: hide has priority over everything, show only starts from hidden.
  always_comb begin
    state_d  = state_q;
    rows_d   = rows_q;
    rows_sum = 9'(rows_q) + RowsStep;
    if (vga.hide) begin
      state_d = StHidden;
      rows_d  = 8'd0;
    end else begin
      unique case (state_q)
        StHidden: begin
          if (vga.show) begin
            state_d = StReveal;
            rows_d  = 8'd0;
          end
        end
        StReveal: begin
          if (vga.frame_tick) begin
            if (rows_sum >= RowsMax) begin
              rows_d  = 8'(RowsMax);
              state_d = StShown;
            end else begin
              rows_d = rows_sum[7:0];
            end
          end
        end
        StShown: ;
        default: begin
          state_d = StHidden;
          rows_d  = 8'd0;
        end
      endcase
    end
    busy_d = (state_d == StReveal);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StHidden;
      rows_q  <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      busy_q  <= busy_d;
    end
  end

  // Window decode in 11 bits so X0+IMG_W may reach the top of the 10-bit range.
  always_comb begin
    in_win = ({1'b0, vga.pixel_x} >= XLo) && ({1'b0, vga.pixel_x} < XHi) &&
             ({1'b0, vga.pixel_y} >= YLo) && ({1'b0, vga.pixel_y} < YHi);
    dx     = vga.pixel_x - XLo[9:0];
    dy     = vga.pixel_y - YLo[9:0];
    addr_d = in_win ? (14'(dy) * 14'(IMG_W) + 14'(dx)) : 14'd0;
    vis    = in_win && ((state_q == StShown) ||
                        ((state_q == StReveal) && (dy < {2'b00, rows_q})));
  end

  always_comb begin
    if (!von_d2_q) begin
      rgb_d = 12'h000;
    end else if (vis_d2_q) begin
      rgb_d = vga.rom_data;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  // Stage 1 feeds the ROM; stage 2 matches the ROM register; stage 3 is the mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr_q <= 14'd0;
      vis_q      <= 1'b0;
      von_q      <= 1'b0;
      vis_d2_q   <= 1'b0;
      von_d2_q   <= 1'b0;
      rgb_q      <= 12'h000;
    end else begin
      rom_addr_q <= addr_d;
      vis_q      <= vis;
      von_q      <= vga.video_on;
      vis_d2_q   <= vis_q;
      von_d2_q   <= von_q;
      rgb_q      <= rgb_d;
    end
  end

  assign vga.rom_addr = rom_addr_q;
  assign vga.rgb      = rgb_q;
  assign vga.busy     = busy_q;

endmodule

// File: tb/tb_question_pixel_fetch.sv
// Directed bench for question_pixel_fetch with a 1-cycle ROM model (data = addr[11:0]).
module tb_question_pixel_fetch;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  question_pixel_fetch_if bus ();

  question_pixel_fetch dut (
    .clk   (clk),
    .reset (reset),
    .vga   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.rom_data <= bus.rom_addr[11:0];

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic [13:0] addr;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.pixel_x    = 10'd0;
    bus.pixel_y    = 10'd0;
    bus.video_on   = 1'b0;
  endtask

  // Drive one pixel, check rom_addr one edge later and rgb three edges later.
  task automatic apply_pixel(input string name, input logic [9:0] x, input logic [9:0] y,
                             input logic von, input logic [13:0] exp_addr,
                             input logic [11:0] exp_rgb);
    @(negedge clk);
    bus.pixel_x  = x;
    bus.pixel_y  = y;
    bus.video_on = von;
    @(posedge clk); #1;
    check({name, ".addr"}, 32'(bus.rom_addr), 32'(exp_addr));
    idle_inputs();
    @(posedge clk);
    @(posedge clk); #1;
    check({name, ".rgb"}, 32'(bus.rgb), 32'(exp_rgb));
  endtask

  // pulse_sel: 0 show, 1 hide, 2 frame_tick, 3 show+hide, 4 show+frame_tick
  task automatic pulse(input int sel);
    @(negedge clk);
    bus.show       = (sel == 0) || (sel == 3) || (sel == 4);
    bus.hide       = (sel == 1) || (sel == 3);
    bus.frame_tick = (sel == 2) || (sel == 4);
    @(posedge clk); #1;
    bus.show       = 1'b0;
    bus.hide       = 1'b0;
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    vecs[0] = '{x: 10'd256, y: 10'd176, von: 1'b1, addr: 14'd0,     rgb: 12'h000};
    vecs[1] = '{x: 10'd257, y: 10'd176, von: 1'b1, addr: 14'd1,     rgb: 12'h001};
    vecs[2] = '{x: 10'd383, y: 10'd303, von: 1'b1, addr: 14'd16383, rgb: 12'hFFF};
    vecs[3] = '{x: 10'd384, y: 10'd176, von: 1'b1, addr: 14'd0,     rgb: 12'h000};
    vecs[4] = '{x: 10'd383, y: 10'd176, von: 1'b1, addr: 14'd127,   rgb: 12'h07F};
    vecs[5] = '{x: 10'd256, y: 10'd303, von: 1'b1, addr: 14'd16256, rgb: 12'hF80};
    vecs[6] = '{x: 10'd300, y: 10'd200, von: 1'b1, addr: 14'd3116,  rgb: 12'hC2C};
    vecs[7] = '{x: 10'd300, y: 10'd200, von: 1'b0, addr: 14'd3116,  rgb: 12'h000};
    vecs[8] = '{x: 10'd255, y: 10'd200, von: 1'b1, addr: 14'd0,     rgb: 12'h000};
    vecs[9] = '{x: 10'd300, y: 10'd304, von: 1'b1, addr: 14'd0,     rgb: 12'h000};

    reset          = 1'b1;
    bus.show       = 1'b0;
    bus.hide       = 1'b0;
    bus.frame_tick = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check("reset.addr", 32'(bus.rom_addr), 0);
    check("reset.rgb", 32'(bus.rgb), 0);
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.rows", 32'(dut.rows_q), 0);
    @(negedge clk);
    reset = 1'b0;

    // Hidden: in-window pixel shows background.
    apply_pixel("hidden", 10'd300, 10'd200, 1'b1, 14'd3116, 12'h000);

    pulse(0);
    check("show.busy", 32'(bus.busy), 1);
    check("show.rows", 32'(dut.rows_q), 0);
    for (int k = 1; k <= 16; k++) begin
      pulse(2);
      check($sformatf("tick%0d.rows", k), 32'(dut.rows_q), 32'(8 * k));
      check($sformatf("tick%0d.busy", k), 32'(bus.busy), (k < 16) ? 1 : 0);
    end
    pulse(2);
    check("shown.sat_rows", 32'(dut.rows_q), 128);
    pulse(0);
    check("shown.show_ignored", 32'(bus.busy), 0);

    for (int i = 0; i < 10; i++) begin
      apply_pixel($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].von,
                  vecs[i].addr, vecs[i].rgb);
    end

    // show and hide together from SHOWN: hide wins.
    pulse(3);
    check("showhide.busy", 32'(bus.busy), 0);
    check("showhide.rows", 32'(dut.rows_q), 0);
    apply_pixel("showhide.pix", 10'd300, 10'd200, 1'b1, 14'd3116, 12'h000);

    // Partial reveal at rows=8.
    pulse(0);
    pulse(2);
    check("reveal8.rows", 32'(dut.rows_q), 8);
    apply_pixel("reveal.y183", 10'd257, 10'd183, 1'b1, 14'd897, 12'h381);
    apply_pixel("reveal.y184", 10'd257, 10'd184, 1'b1, 14'd1025, 12'h000);
    pulse(0);
    check("reveal.show_ignored", 32'(dut.rows_q), 8);

    // show with frame_tick from HIDDEN enters REVEAL at rows=0.
    pulse(1);
    pulse(4);
    check("showtick.busy", 32'(bus.busy), 1);
    check("showtick.rows", 32'(dut.rows_q), 0);
    pulse(2);
    check("showtick.next", 32'(dut.rows_q), 8);

    // Reset mid-reveal with an in-window pixel in flight.
    @(negedge clk);
    bus.pixel_x  = 10'd257;
    bus.pixel_y  = 10'd176;
    bus.video_on = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset.addr", 32'(bus.rom_addr), 0);
    check("midreset.rgb", 32'(bus.rgb), 0);
    check("midreset.busy", 32'(bus.busy), 0);
    check("midreset.rows", 32'(dut.rows_q), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("flush%0d.rgb", c), 32'(bus.rgb), 0);
    end
    idle_inputs();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
